// File: rtl/serial_link_pkg.sv
// Shared definitions for the telemetry frame unpacker: FSM states, event flags,
// parameter bounds and the K-frame format constants.
package serial_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DONE    = 3'd3,
    ST_DISCARD = 3'd4
  } state_e;

  typedef struct packed {
    logic valid;
    logic short_len;
    logic long_len;
    logic bad_stream;
  } evt_t;

  localparam int DATA_WIDTH_MIN  = 1;
  localparam int DATA_WIDTH_MAX  = 32;
  localparam int NUM_STREAMS_MIN = 1;
  localparam int NUM_STREAMS_MAX = 16;

  // Frame layout: K, one header byte carrying the stream ID, payload, K.
  localparam int FRAME_HDR_BYTES = 1;
  localparam logic [7:0] K28_5   = 8'hBC;

  function automatic int stream_width(input int num_streams);
    return (num_streams < 2) ? 1 : $clog2(num_streams);
  endfunction

endpackage

// File: rtl/unpack_telemetry_multi_if.sv
// Byte-stream input and frame/error output bundle of the telemetry unpacker.
interface unpack_telemetry_multi_if #(
  parameter int g_data_width   = 11,
  parameter int g_stream_width = 2
);
  logic                      k_in;
  logic [7:0]                data_in;
  logic                      valid_in;
  logic [8*g_data_width-1:0] data_out;
  logic [g_stream_width-1:0] stream_out;
  logic                      valid_out;
  logic                      err_short;
  logic                      err_long;
  logic                      err_stream;

  modport master (
    output k_in, data_in, valid_in,
    input  data_out, stream_out, valid_out, err_short, err_long, err_stream
  );

  modport slave (
    input  k_in, data_in, valid_in,
    output data_out, stream_out, valid_out, err_short, err_long, err_stream
  );
endinterface

// File: rtl/unpack_telemetry_multi.sv
// Telemetry frame unpacker: K, stream-ID header, fixed-length payload, K.
// Frames assemble in one register and are copied to a separate output register on emission.
module unpack_telemetry_multi
  import serial_link_pkg::*;
#(
  parameter int g_data_width  = 11,
  parameter int g_num_streams = 4,
  parameter bit g_strict      = 1'b0
) (
  input logic                     clk,
  input logic                     rst,
  unpack_telemetry_multi_if.slave bus
);

  localparam int SW    = stream_width(g_num_streams);
  localparam int DW    = 8 * g_data_width;
  localparam int CNT_W = $clog2(g_data_width + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(g_data_width - 1);
  localparam logic [8:0]       NUM_STREAMS = 9'(g_num_streams);

  generate
    if (g_data_width < DATA_WIDTH_MIN || g_data_width > DATA_WIDTH_MAX) begin : g_bad_width
      $error("unpack_telemetry_multi: g_data_width out of range");
    end
    if (g_num_streams < NUM_STREAMS_MIN || g_num_streams > NUM_STREAMS_MAX) begin : g_bad_streams
      $error("unpack_telemetry_multi: g_num_streams out of range");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SW-1:0]    id_q, id_d;
  logic [DW-1:0]    asm_q, asm_d;
  evt_t             evt_s;
  evt_t             pend_q;
  evt_t             evt_q;
  logic [DW-1:0]    data_q;
  logic [SW-1:0]    stream_q;

  // Frame-tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      id_q    <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      id_q    <= id_d;
      asm_q   <= asm_d;
    end
  end

  // Next-state decode; one valid symbol yields at most one event.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    id_d    = id_q;
    asm_d   = asm_q;
    evt_s   = '0;
    if (bus.valid_in) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.k_in) state_d = ST_HDR;
          else          state_d = ST_IDLE;
        end
        ST_HDR: begin
          if (bus.k_in) begin
            state_d = ST_HDR;
          end else if ({1'b0, bus.data_in} < NUM_STREAMS) begin
            id_d    = bus.data_in[SW-1:0];
            count_d = '0;
            state_d = ST_PAYLOAD;
          end else begin
            evt_s.bad_stream = 1'b1;
            state_d          = ST_DISCARD;
          end
        end
        ST_PAYLOAD: begin
          if (bus.k_in) begin
            evt_s.short_len = 1'b1;
            state_d         = ST_HDR;
          end else begin
            for (int b = 0; b < g_data_width; b++) begin
              asm_d[8*b +: 8] = (count_q == CNT_W'(b)) ? bus.data_in : asm_q[8*b +: 8];
            end
            // Counter stops at g_data_width, which its width always holds.
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_LAST) begin
              state_d     = ST_DONE;
              evt_s.valid = ~g_strict;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
        end
        ST_DONE: begin
          if (bus.k_in) begin
            evt_s.valid = g_strict;
            state_d     = ST_HDR;
          end else begin
            evt_s.long_len = 1'b1;
            state_d        = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (bus.k_in) state_d = ST_HDR;
          else          state_d = ST_DISCARD;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Emission stage: the finished frame is copied out while the assembly register refills.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      evt_q    <= '0;
      data_q   <= '0;
      stream_q <= '0;
    end else begin
      pend_q <= evt_s;
      evt_q  <= pend_q;
      if (pend_q.valid) begin
        data_q   <= asm_q;
        stream_q <= id_q;
      end else begin
        data_q   <= data_q;
        stream_q <= stream_q;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.stream_out = stream_q;
  assign bus.valid_out  = evt_q.valid;
  assign bus.err_short  = evt_q.short_len;
  assign bus.err_long   = evt_q.long_len;
  assign bus.err_stream = evt_q.bad_stream;

endmodule

// File: doc/unpack_telemetry_multi.md
UNPACK_TELEMETRY_MULTI -- requirements
Module: unpack_telemetry_multi

Interface
REQ-001 Parameter g_data_width, default 11: payload bytes per frame; legal range 1..32; elaboration SHALL fail outside it.
REQ-002 Parameter g_num_streams, default 4: number of legal stream IDs; legal range 1..16; elaboration SHALL fail outside it.
REQ-003 Parameter g_strict, default 0: 0 = emit frame on last payload byte; 1 = emit only after a terminating K confirms exact length.
REQ-004 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 k_in  in  1  current byte is a K character.
REQ-007 data_in  in  8  decoded byte from the 8b10b decoder.
REQ-008 valid_in  in  1  k_in/data_in qualify; nothing advances while low.
REQ-009 data_out  out  8*g_data_width  assembled payload; byte 0 in bits [7:0].
REQ-010 stream_out  out  SW = max(1, clog2(g_num_streams))  stream ID of the frame on data_out.
REQ-011 valid_out  out  1  one-cycle pulse; data_out/stream_out are valid.
REQ-012 err_short, err_long, err_stream  out  1 each  one-cycle error pulses.

Function
REQ-013 Frame format SHALL be: K, header byte (stream ID), then g_data_width payload bytes, then K (the next frame's K, or idle K).
REQ-014 States SHALL be: IDLE, HDR, PAYLOAD, DONE, DISCARD; only cycles with valid_in=1 cause transitions.
REQ-015 IDLE: K -> HDR; data is ignored with no error.
REQ-016 HDR: K -> HDR (idle fill, no error); data with ID < g_num_streams -> latch ID, count=0, PAYLOAD; data with ID >= g_num_streams -> err_stream pulse, DISCARD.
REQ-017 PAYLOAD: data byte n SHALL be written to bits [8n+7:8n], count+1; the last byte (count = g_data_width-1) -> DONE.
REQ-018 PAYLOAD: K with count < g_data_width -> err_short pulse, frame dropped, HDR.
REQ-019 g_strict=0: valid_out SHALL assert on the edge after the edge capturing the last payload byte (1-cycle latency).
REQ-020 g_strict=1: valid_out SHALL assert on the edge after the edge capturing the K in DONE; DONE + K -> HDR.
REQ-021 DONE: data -> err_long pulse (once per frame), DISCARD; when g_strict=1 the frame SHALL NOT be emitted.
REQ-022 g_strict=0, DONE + K -> HDR with no extra output.
REQ-023 DISCARD: data is ignored; K -> HDR.
REQ-024 A back-to-back frame (K immediately followed by a header) SHALL be accepted with no idle cycle; the assembly register SHALL be double-buffered so that emitted data_out is stable while the next frame fills.
REQ-025 data_out/stream_out SHALL hold their last emitted value between valid_out pulses; they change only together with a valid_out pulse.
REQ-026 At most one of err_short/err_long/err_stream SHALL pulse per cycle, and never in the same cycle as valid_out for the same frame.
REQ-027 The frame length counter SHALL be sized to g_data_width, never wrap, and never re-emit a stale frame if the link stops.

Reset
REQ-028 rst=1 SHALL force: state IDLE, count 0, valid_out 0, all err_* 0, data_out 0, stream_out 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; a fresh K SHALL be required before any header is accepted.
REQ-030 A K or data byte coincident with rst=1 SHALL be ignored.

Structure
REQ-031 State encoding, legal parameter bounds and the K-frame format constants SHALL live in serial_link_pkg.
REQ-032 No sub-module is required; a single module holding the FSM, counter and assembly/output registers.

Verification
REQ-033 Defaults: K, 0x02, bytes 0x10..0x1A, K -> one valid_out, stream_out=2, data_out=0x1A19..1110 (byte 0 = 0x10) one cycle after 0x1A.
REQ-034 g_strict=1: same frame -> valid_out one cycle after the trailing K; the frame with a 12th byte 0xFF -> err_long, no valid_out.
REQ-035 K, 0x01, 5 bytes, K -> err_short on the K; the following frame decodes correctly.
REQ-036 K, header 0x07 (g_num_streams=4) -> err_stream, all bytes until the next K are ignored.
REQ-037 rst pulsed after 6 payload bytes, then the remaining 5 bytes with no K -> no output; K + full frame -> normal output.
REQ-038 g_data_width=1 and 32, valid_in toggling every other cycle, back-to-back frames -> every frame emitted exactly once and in order.
